// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the core's memory stage and data_mem_ctrl.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable RV32 data memory, valid/ready request, registered one-cycle response.
// Define DMEM_MISALIGN_SPLIT_EN to execute misaligned accesses as two consecutive word accesses.
module data_mem_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_ctrl_if.slave bus
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int WORDS = 1 << IDX_W;

`ifdef DMEM_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_ACC2 = 2'd2,
        ST_RSP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RSP  = 2'd3
    } state_t;
`endif

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = !we;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                 input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return r;
    endfunction

    // Little-endian bytes starting at lane off, continuing into the following word.
    function automatic logic [31:0] assemble(input logic [31:0] lo, input logic [31:0] hi,
                                             input logic [1:0] off);
        logic [31:0] r;
        case (off)
            2'd1:    r = {hi[7:0],  lo[31:8]};
            2'd2:    r = {hi[15:0], lo[31:16]};
            2'd3:    r = {hi[23:0], lo[31:24]};
            default: r = lo;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b010:  r = d;
            3'b100:  r = {24'h00_0000, d[7:0]};
            3'b101:  r = {16'h0000, d[15:0]};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

`ifdef DMEM_MISALIGN_SPLIT_EN
    function automatic logic [3:0] hi_lanes(input logic [3:0] mask, input logic [1:0] off);
        logic [3:0] r;
        case (off)
            2'd1:    r = {3'b000, mask[3]};
            2'd2:    r = {2'b00, mask[3:2]};
            2'd3:    r = {1'b0, mask[3:1]};
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] hi_data(input logic [31:0] w, input logic [1:0] off);
        logic [31:0] r;
        case (off)
            2'd1:    r = {24'h00_0000, w[31:24]};
            2'd2:    r = {16'h0000, w[31:16]};
            2'd3:    r = {8'h00, w[31:8]};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction
`else
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic m;
        case (f3[1:0])
            2'b01:   m = off[0];
            2'b10:   m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction
`endif

    state_t            state_r;
    state_t            state_nx_s;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic [31:0]       rsp_rdata_r;
    logic              rsp_valid_nx_s;
    logic              rsp_err_nx_s;
    logic [31:0]       rsp_rdata_nx_s;
    logic              mem_we_lo_s;

    // Not touched by rst_n; the power-up image carries a known pattern in word 0.
    logic [31:0] mem_r [WORDS] = '{0: 32'hFFCC_DDEE, default: 32'h0000_0000};

    logic [1:0]       off_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      lo_word_s;
    logic [3:0]       be_lo_s;
    logic [31:0]      wd_lo_s;
    logic [31:0]      load_data_s;

    assign off_s     = addr_r[1:0];
    assign idx_s     = addr_r[ADDR_W-1:2];
    assign lo_word_s = mem_r[idx_s];
    assign be_lo_s   = size_mask(funct3_r) << off_s;
    assign wd_lo_s   = wdata_r << {off_s, 3'b000};

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [IDX_W-1:0] idx_hi_s;
    logic [31:0]      hi_word_s;
    logic [31:0]      hold_r;
    logic [3:0]       be_hi_s;
    logic [31:0]      wd_hi_s;
    logic [31:0]      lo_src_s;
    logic             cross_s;
    logic             mem_we_hi_s;

    // Index arithmetic wraps naturally from the top word back to word 0.
    assign idx_hi_s    = idx_s + IDX_W'(1);
    assign hi_word_s   = mem_r[idx_hi_s];
    assign be_hi_s     = hi_lanes(size_mask(funct3_r), off_s);
    assign wd_hi_s     = hi_data(wdata_r, off_s);
    assign cross_s     = |be_hi_s;
    assign lo_src_s    = (state_r == ST_ACC2) ? hold_r : lo_word_s;
    assign load_data_s = format_load(funct3_r, assemble(lo_src_s, hi_word_s, off_s));

    // Low word of a split load, kept for assembly during ACC2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r <= 32'h0000_0000;
        end else if (state_r == ST_ACC && !we_r) begin
            hold_r <= lo_word_s;
        end
    end
`else
    assign load_data_s = format_load(funct3_r, assemble(lo_word_s, 32'h0000_0000, off_s));
`endif

    // Byte-lane writes into the word array.
    always_ff @(posedge clk) begin
        if (mem_we_lo_s) begin
            mem_r[idx_s] <= merge_lanes(lo_word_s, wd_lo_s, be_lo_s);
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (mem_we_hi_s) begin
            mem_r[idx_hi_s] <= merge_lanes(hi_word_s, wd_hi_s, be_hi_s);
        end
`endif
    end

    // Next-state, array write strobes and the response about to be registered.
    always_comb begin
        state_nx_s     = state_r;
        rsp_valid_nx_s = 1'b0;
        rsp_err_nx_s   = 1'b0;
        rsp_rdata_nx_s = 32'h0000_0000;
        mem_we_lo_s    = 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
        mem_we_hi_s    = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (!funct3_legal(bus.req_we, bus.req_funct3)) begin
                        state_nx_s     = ST_RSP;
                        rsp_valid_nx_s = 1'b1;
                        rsp_err_nx_s   = 1'b1;
`ifndef DMEM_MISALIGN_SPLIT_EN
                    end else if (is_misaligned(bus.req_funct3, bus.req_addr[1:0])) begin
                        state_nx_s     = ST_RSP;
                        rsp_valid_nx_s = 1'b1;
                        rsp_err_nx_s   = 1'b1;
`endif
                    end else begin
                        state_nx_s = ST_ACC;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                mem_we_lo_s = we_r;
`ifdef DMEM_MISALIGN_SPLIT_EN
                if (cross_s) begin
                    state_nx_s = ST_ACC2;
                end else begin
                    state_nx_s     = ST_RSP;
                    rsp_valid_nx_s = 1'b1;
                    rsp_rdata_nx_s = we_r ? 32'h0000_0000 : load_data_s;
                end
`else
                state_nx_s     = ST_RSP;
                rsp_valid_nx_s = 1'b1;
                rsp_rdata_nx_s = we_r ? 32'h0000_0000 : load_data_s;
`endif
            end
`ifdef DMEM_MISALIGN_SPLIT_EN
            ST_ACC2: begin
                mem_we_hi_s    = we_r;
                state_nx_s     = ST_RSP;
                rsp_valid_nx_s = 1'b1;
                rsp_rdata_nx_s = we_r ? 32'h0000_0000 : load_data_s;
            end
`endif
            ST_RSP: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, request capture and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            we_r        <= 1'b0;
            funct3_r    <= 3'b000;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= 32'h0000_0000;
        end else begin
            state_r     <= state_nx_s;
            rsp_valid_r <= rsp_valid_nx_s;
            rsp_err_r   <= rsp_err_nx_s;
            rsp_rdata_r <= rsp_rdata_nx_s;
            if (state_r == ST_IDLE && bus.req_valid) begin
                we_r     <= bus.req_we;
                funct3_r <= bus.req_funct3;
                addr_r   <= bus.req_addr;
                wdata_r  <= bus.req_wdata;
            end
        end
    end

    assign bus.req_ready = (state_r == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_rdata_r;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: requests push expected responses, a monitor pops and compares.
module tb_data_mem_ctrl;
    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    data_mem_ctrl_if #(.ADDR_W(10)) bus ();

    data_mem_ctrl #(.ADDR_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    // Monitor: every response strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=rsp_valid expected=no response");
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "_rdata"}, bus.rsp_rdata, mon_e.rdata);
                chk({mon_e.name, "_err"}, 32'(bus.rsp_err), 32'(mon_e.err));
                chk({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic wait_ready(input string name);
        int guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout actual=0 expected=1", name);
        end
    endtask

    // lat = accept edge to the edge that consumes the response.
    task automatic send(input string name, input logic we, input logic [2:0] f3,
                        input logic [9:0] addr, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int lat, input logic junk);
        exp_t e;
        int   guard = 0;
        wait_ready(name);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        e.rdata = er;
        e.err   = ee;
        e.cyc   = cyc + lat - 1;
        e.name  = name;
        sb_q.push_back(e);
        @(negedge clk);
        if (junk) begin
            chk({name, "_ready_acc"}, 32'(bus.req_ready), 32'd0);
            bus.req_we     = 1'b1;
            bus.req_funct3 = F_W;
            bus.req_addr   = 10'h010;
            bus.req_wdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            chk({name, "_ready_rsp"}, 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        while (sb_q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_rsp_timeout actual=no response expected=rsp_valid", name);
            sb_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 10'h000;
        bus.req_wdata  = 32'h0000_0000;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'h0000_0000);
        chk("rst_err", 32'(bus.rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send("lw_0",   1'b0, F_W,  10'h000, 32'h0, 32'hFFCC_DDEE, 1'b0, 2, 1'b0);
        send("lb_3",   1'b0, F_B,  10'h003, 32'h0, 32'hFFFF_FFFF, 1'b0, 2, 1'b0);
        send("lbu_3",  1'b0, F_BU, 10'h003, 32'h0, 32'h0000_00FF, 1'b0, 2, 1'b0);
        send("lh_2",   1'b0, F_H,  10'h002, 32'h0, 32'hFFFF_FFCC, 1'b0, 2, 1'b0);
        send("lhu_0",  1'b0, F_HU, 10'h000, 32'h0, 32'h0000_DDEE, 1'b0, 2, 1'b0);

        send("sw_10",  1'b1, F_W,  10'h010, 32'h1234_5678, 32'h0, 1'b0, 2, 1'b1);
        send("sb_11",  1'b1, F_B,  10'h011, 32'h0000_00AB, 32'h0, 1'b0, 2, 1'b0);
        send("sh_12",  1'b1, F_H,  10'h012, 32'h0000_BEEF, 32'h0, 1'b0, 2, 1'b0);
        send("lw_10",  1'b0, F_W,  10'h010, 32'h0, 32'hBEEF_AB78, 1'b0, 2, 1'b0);
        send("lb_13",  1'b0, F_B,  10'h013, 32'h0, 32'hFFFF_FFBE, 1'b0, 2, 1'b0);
        send("lhu_12", 1'b0, F_HU, 10'h012, 32'h0, 32'h0000_BEEF, 1'b0, 2, 1'b0);

        send("ld_011",  1'b0, 3'b011, 10'h020, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        send("st_100",  1'b1, 3'b100, 10'h020, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b0);
        send("lw_20_a", 1'b0, F_W,    10'h020, 32'h0, 32'h0, 1'b0, 2, 1'b0);

`ifdef DMEM_MISALIGN_SPLIT_EN
        send("sw_21",   1'b1, F_W, 10'h021, 32'hA1B2_C3D4, 32'h0, 1'b0, 3, 1'b0);
        send("lw_21",   1'b0, F_W, 10'h021, 32'h0, 32'hA1B2_C3D4, 1'b0, 3, 1'b0);
        send("lw_20_b", 1'b0, F_W, 10'h020, 32'h0, 32'hB2C3_D400, 1'b0, 2, 1'b0);
        send("lw_24",   1'b0, F_W, 10'h024, 32'h0, 32'h0000_00A1, 1'b0, 2, 1'b0);
        send("lh_23",   1'b0, F_H, 10'h023, 32'h0, 32'hFFFF_A1B2, 1'b0, 3, 1'b0);
        send("lh_21",   1'b0, F_H, 10'h021, 32'h0, 32'hFFFF_C3D4, 1'b0, 2, 1'b0);
        send("lw_top",  1'b0, F_W, 10'h3FE, 32'h0, 32'hDDEE_0000, 1'b0, 3, 1'b0);
`else
        send("sw_21",   1'b1, F_W, 10'h021, 32'hA1B2_C3D4, 32'h0, 1'b1, 1, 1'b0);
        send("lw_21",   1'b0, F_W, 10'h021, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        send("lw_20_b", 1'b0, F_W, 10'h020, 32'h0, 32'h0, 1'b0, 2, 1'b0);
        send("lw_24",   1'b0, F_W, 10'h024, 32'h0, 32'h0, 1'b0, 2, 1'b0);
        send("lh_23",   1'b0, F_H, 10'h023, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        send("lh_21",   1'b0, F_H, 10'h021, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        send("lw_top",  1'b0, F_W, 10'h3FE, 32'h0, 32'h0, 1'b1, 1, 1'b0);
`endif

        // Abort a store in flight: no response may appear afterwards.
        wait_ready("abort");
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F_W;
`ifdef DMEM_MISALIGN_SPLIT_EN
        bus.req_addr   = 10'h031;
`else
        bus.req_addr   = 10'h030;
`endif
        bus.req_wdata  = 32'h1122_3344;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
        @(negedge clk);
`endif
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_rdata", bus.rsp_rdata, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
`ifdef DMEM_MISALIGN_SPLIT_EN
        send("lw_30", 1'b0, F_W, 10'h030, 32'h0, 32'h2233_4400, 1'b0, 2, 1'b0);
`else
        send("lw_30", 1'b0, F_W, 10'h030, 32'h0, 32'h0000_0000, 1'b0, 2, 1'b0);
`endif
        send("lw_34", 1'b0, F_W, 10'h034, 32'h0, 32'h0000_0000, 1'b0, 2, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
